// File: rtl/ibex_branch_resolve.sv
// Tracks predicted control-flow instructions in an in-order FIFO and resolves them
// oldest-first, raising a registered redirect on mispredict and counting outcomes.
module ibex_branch_resolve #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_valid_i,
  output logic                     push_ready_o,
  input  logic [31:0]              push_pc_i,
  input  logic                     push_compressed_i,
  input  logic                     push_taken_i,
  input  logic [31:0]              push_target_i,
  input  logic                     resolve_valid_i,
  input  logic                     resolve_taken_i,
  input  logic [31:0]              resolve_target_i,
  input  logic                     flush_i,
  output logic                     redirect_valid_o,
  output logic [31:0]              redirect_pc_o,
  output logic                     resolve_err_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic [CNT_W-1:0]         branch_cnt_o,
  output logic [CNT_W-1:0]         mispredict_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [31:0] pc_q    [DEPTH];
  logic        comp_q  [DEPTH];
  logic        taken_q [DEPTH];
  logic [31:0] tgt_q   [DEPTH];

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic             full, empty, push_acc, res_ok, mispred, redir_fire, err_fire;
  logic [31:0]      fall_pc, redir_pc;
  logic             redirect_valid_q, resolve_err_q;
  logic [31:0]      redirect_pc_q;
  logic [CNT_W-1:0] branch_cnt_q, mispredict_cnt_q;

  // Handshake: a push transfers when push_valid_i && push_ready_o at a rising edge;
  // ready depends only on registered occupancy, never on resolve_valid_i.
  always_comb begin
    wr_idx     = wr_q[AW-1:0];
    rd_idx     = rd_q[AW-1:0];
    empty      = (wr_q == rd_q);
    full       = (wr_q[AW] != rd_q[AW]) && (wr_idx == rd_idx);
    push_acc   = push_valid_i && !full;
    res_ok     = resolve_valid_i && !empty;
    fall_pc    = pc_q[rd_idx] + (comp_q[rd_idx] ? 32'd2 : 32'd4);
    mispred    = (taken_q[rd_idx] != resolve_taken_i) ||
                 (taken_q[rd_idx] && (tgt_q[rd_idx] != resolve_target_i));
    redir_pc   = resolve_taken_i ? resolve_target_i : fall_pc;
    redir_fire = !flush_i && res_ok && mispred;
    err_fire   = !flush_i && resolve_valid_i && empty;

    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      rd_d = wr_q;
    end else if (redir_fire) begin
      // Everything younger than the mispredicted entry is wrong-path, including a same-cycle push.
      rd_d = wr_q;
    end else begin
      if (push_acc) wr_d = wr_q + PTR_ONE;
      if (res_ok)   rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q             <= '0;
      rd_q             <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      resolve_err_q    <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        comp_q[i]  <= 1'b0;
        taken_q[i] <= 1'b0;
        tgt_q[i]   <= '0;
      end
    end else begin
      wr_q             <= wr_d;
      rd_q             <= rd_d;
      redirect_valid_q <= redir_fire;
      resolve_err_q    <= err_fire;
      if (redir_fire) redirect_pc_q <= redir_pc;
      if (push_acc && !flush_i && !redir_fire) begin
        pc_q[wr_idx]    <= push_pc_i;
        comp_q[wr_idx]  <= push_compressed_i;
        taken_q[wr_idx] <= push_taken_i;
        tgt_q[wr_idx]   <= push_target_i;
      end
      if (!flush_i && res_ok && (branch_cnt_q != CNT_MAX))
        branch_cnt_q <= branch_cnt_q + CNT_ONE;
      if (redir_fire && (mispredict_cnt_q != CNT_MAX))
        mispredict_cnt_q <= mispredict_cnt_q + CNT_ONE;
    end
  end

  assign push_ready_o     = !full;
  assign occupancy_o      = wr_q - rd_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign resolve_err_o    = resolve_err_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule

// File: tb/tb_ibex_branch_resolve.sv
// Bench for ibex_branch_resolve: directed scenarios plus random traffic against a queue model;
// a second instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_ibex_branch_resolve;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        push_valid_i, push_compressed_i, push_taken_i;
  logic [31:0] push_pc_i, push_target_i;
  logic        resolve_valid_i, resolve_taken_i, flush_i;
  logic [31:0] resolve_target_i;

  logic        push_ready_o, redirect_valid_o, resolve_err_o;
  logic [31:0] redirect_pc_o;
  logic [2:0]  occupancy_o;
  logic [15:0] branch_cnt_o, mispredict_cnt_o;

  logic        s_ready, s_rv, s_err;
  logic [31:0] s_rpc;
  logic [2:0]  s_occ;
  logic [1:0]  s_bc, s_mc;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic        c;
    logic        t;
    logic [31:0] tgt;
  } ent_t;

  ent_t        mq[$];
  logic        m_rv, m_err;
  logic [31:0] m_rpc;
  int          m_bc, m_mc;

  always #5 clk = ~clk;

  ibex_branch_resolve #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o), .push_pc_i(push_pc_i),
    .push_compressed_i(push_compressed_i), .push_taken_i(push_taken_i), .push_target_i(push_target_i),
    .resolve_valid_i(resolve_valid_i), .resolve_taken_i(resolve_taken_i),
    .resolve_target_i(resolve_target_i), .flush_i(flush_i),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .resolve_err_o(resolve_err_o), .occupancy_o(occupancy_o),
    .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
  );

  ibex_branch_resolve #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst_i),
    .push_valid_i(push_valid_i), .push_ready_o(s_ready), .push_pc_i(push_pc_i),
    .push_compressed_i(push_compressed_i), .push_taken_i(push_taken_i), .push_target_i(push_target_i),
    .resolve_valid_i(resolve_valid_i), .resolve_taken_i(resolve_taken_i),
    .resolve_target_i(resolve_target_i), .flush_i(flush_i),
    .redirect_valid_o(s_rv), .redirect_pc_o(s_rpc),
    .resolve_err_o(s_err), .occupancy_o(s_occ),
    .branch_cnt_o(s_bc), .mispredict_cnt_o(s_mc)
  );

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rv = 1'b0; m_err = 1'b0; m_rpc = '0; m_bc = 0; m_mc = 0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    push_valid_i = 0; push_pc_i = '0; push_compressed_i = 0; push_taken_i = 0; push_target_i = '0;
    resolve_valid_i = 0; resolve_taken_i = 0; resolve_target_i = '0; flush_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    model_reset();
  endtask

  // Drives one cycle of inputs and advances the reference model at the same edge.
  task automatic cycle(input logic pv, input logic [31:0] pc, input logic c, input logic t,
                       input logic [31:0] tgt, input logic rv, input logic rt,
                       input logic [31:0] rtgt, input logic fl);
    ent_t e;
    bit   acc, mis;
    push_valid_i = pv; push_pc_i = pc; push_compressed_i = c; push_taken_i = t; push_target_i = tgt;
    resolve_valid_i = rv; resolve_taken_i = rt; resolve_target_i = rtgt; flush_i = fl;
    @(posedge clk);
    m_rv = 1'b0; m_err = 1'b0;
    acc = pv && (mq.size() < DEPTH);
    if (fl) begin
      mq.delete();
    end else if (rv && mq.size() == 0) begin
      m_err = 1'b1;
      if (acc) mq.push_back('{pc, c, t, tgt});
    end else if (rv) begin
      e = mq.pop_front();
      m_bc++;
      mis = (e.t != rt) || (e.t && rt && e.tgt != rtgt);
      if (mis) begin
        m_mc++;
        m_rv = 1'b1;
        m_rpc = rt ? rtgt : e.pc + (e.c ? 32'd2 : 32'd4);
        mq.delete();
      end else if (acc) begin
        mq.push_back('{pc, c, t, tgt});
      end
    end else if (acc) begin
      mq.push_back('{pc, c, t, tgt});
    end
    #1;
  endtask

  task automatic idle();
    cycle(0, '0, 0, 0, '0, 0, 0, '0, 0);
  endtask

  task automatic push(input logic [31:0] pc, input logic c, input logic t, input logic [31:0] tgt);
    cycle(1, pc, c, t, tgt, 0, 0, '0, 0);
  endtask

  task automatic resolve(input logic rt, input logic [31:0] rtgt);
    cycle(0, '0, 0, 0, '0, 1, rt, rtgt, 0);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_rv: got %b exp 0", redirect_valid_o); end
    n_vec++; if (redirect_pc_o !== 32'h0) begin n_err++; $display("FAIL reset_rpc: got %h exp 0", redirect_pc_o); end
    n_vec++; if (occupancy_o !== 3'd0) begin n_err++; $display("FAIL reset_occ: got %0d exp 0", occupancy_o); end
    n_vec++; if (push_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b exp 1", push_ready_o); end
    n_vec++; if (resolve_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b exp 0", resolve_err_o); end
    n_vec++; if (branch_cnt_o !== 16'd0 || mispredict_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", branch_cnt_o, mispredict_cnt_o); end
  endtask

  task automatic test_mispredict_taken();
    push(32'h100, 0, 1, 32'hF0);
    n_vec++; if (occupancy_o !== 3'd1) begin n_err++; $display("FAIL mt_occ_push: got %0d exp 1", occupancy_o); end
    resolve(0, 32'h0);
    n_vec++; if (redirect_valid_o !== 1'b1) begin n_err++; $display("FAIL mt_rv: got %b exp 1", redirect_valid_o); end
    n_vec++; if (redirect_pc_o !== 32'h104) begin n_err++; $display("FAIL mt_rpc: got %h exp 104", redirect_pc_o); end
    n_vec++; if (occupancy_o !== 3'd0) begin n_err++; $display("FAIL mt_occ: got %0d exp 0", occupancy_o); end
    n_vec++; if (branch_cnt_o !== 16'd1 || mispredict_cnt_o !== 16'd1) begin n_err++; $display("FAIL mt_cnt: got %0d/%0d exp 1/1", branch_cnt_o, mispredict_cnt_o); end
    idle();
    n_vec++; if (redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL mt_pulse: got %b exp 0", redirect_valid_o); end
    n_vec++; if (redirect_pc_o !== 32'h104) begin n_err++; $display("FAIL mt_hold: got %h exp 104", redirect_pc_o); end
  endtask

  task automatic test_counter_saturation();
    for (int i = 0; i < 4; i++) begin
      push(32'h1000 + 32'(i * 16), 0, 1, 32'h80);
      resolve(0, 32'h0);
      n_vec++; if (redirect_valid_o !== 1'b1) begin n_err++; $display("FAIL sat_rv%0d: got %b exp 1", i, redirect_valid_o); end
    end
    n_vec++; if (mispredict_cnt_o !== 16'd5) begin n_err++; $display("FAIL sat_mc16: got %0d exp 5", mispredict_cnt_o); end
    n_vec++; if (s_mc !== 2'd3) begin n_err++; $display("FAIL sat_mc2: got %0d exp 3", s_mc); end
    n_vec++; if (s_bc !== 2'd3) begin n_err++; $display("FAIL sat_bc2: got %0d exp 3", s_bc); end
  endtask

  task automatic test_mispredict_not_taken();
    push(32'h200, 1, 0, 32'h0);
    resolve(1, 32'h240);
    n_vec++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h240) begin n_err++; $display("FAIL mnt_redirect: got %b/%h exp 1/240", redirect_valid_o, redirect_pc_o); end
    push(32'h300, 0, 1, 32'h380);
    resolve(1, 32'h380);
    n_vec++; if (redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL correct_rv: got %b exp 0", redirect_valid_o); end
    n_vec++; if (redirect_pc_o !== 32'h240) begin n_err++; $display("FAIL correct_hold: got %h exp 240", redirect_pc_o); end
    n_vec++; if (branch_cnt_o !== 16'd7 || mispredict_cnt_o !== 16'd6) begin n_err++; $display("FAIL correct_cnt: got %0d/%0d exp 7/6", branch_cnt_o, mispredict_cnt_o); end
    push(32'h400, 0, 1, 32'h480);
    resolve(1, 32'h484);
    n_vec++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h484) begin n_err++; $display("FAIL tgt_diff: got %b/%h exp 1/484", redirect_valid_o, redirect_pc_o); end
    push(32'hFFFF_FFFE, 1, 1, 32'h10);
    resolve(0, 32'h0);
    n_vec++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h0) begin n_err++; $display("FAIL pc_wrap: got %b/%h exp 1/0", redirect_valid_o, redirect_pc_o); end
  endtask

  task automatic test_full_backpressure();
    for (int i = 0; i < DEPTH; i++) push(32'h5000 + 32'(i * 4), 0, 0, 32'h0);
    n_vec++; if (occupancy_o !== 3'd4) begin n_err++; $display("FAIL full_occ: got %0d exp 4", occupancy_o); end
    n_vec++; if (push_ready_o !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b exp 0", push_ready_o); end
    cycle(1, 32'h6000, 0, 0, '0, 1, 0, '0, 0);
    n_vec++; if (occupancy_o !== 3'd3) begin n_err++; $display("FAIL full_reject: got %0d exp 3", occupancy_o); end
    n_vec++; if (redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL full_rv: got %b exp 0", redirect_valid_o); end
    push(32'h6000, 0, 0, 32'h0);
    n_vec++; if (occupancy_o !== 3'd4) begin n_err++; $display("FAIL full_accept: got %0d exp 4", occupancy_o); end
    for (int i = 1; i < DEPTH; i++) resolve(0, '0);
    resolve(1, 32'h7000);
    n_vec++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h7000) begin n_err++; $display("FAIL full_order: got %b/%h exp 1/7000", redirect_valid_o, redirect_pc_o); end
  endtask

  task automatic test_flush_on_mispredict();
    push(32'h700, 0, 1, 32'h7F0);
    push(32'h710, 0, 0, 32'h0);
    push(32'h720, 0, 0, 32'h0);
    cycle(1, 32'h730, 0, 0, '0, 1, 0, '0, 0);
    n_vec++; if (occupancy_o !== 3'd0) begin n_err++; $display("FAIL wp_occ: got %0d exp 0", occupancy_o); end
    n_vec++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h704) begin n_err++; $display("FAIL wp_redirect: got %b/%h exp 1/704", redirect_valid_o, redirect_pc_o); end
    idle();
    n_vec++; if (redirect_valid_o !== 1'b0 || occupancy_o !== 3'd0) begin n_err++; $display("FAIL wp_single: got %b/%0d exp 0/0", redirect_valid_o, occupancy_o); end
  endtask

  task automatic test_empty_resolve_and_flush();
    int bc0, mc0;
    bc0 = branch_cnt_o; mc0 = mispredict_cnt_o;
    resolve(1, 32'h9000);
    n_vec++; if (resolve_err_o !== 1'b1) begin n_err++; $display("FAIL empty_err: got %b exp 1", resolve_err_o); end
    n_vec++; if (redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL empty_rv: got %b exp 0", redirect_valid_o); end
    n_vec++; if (int'(branch_cnt_o) != bc0 || int'(mispredict_cnt_o) != mc0) begin n_err++; $display("FAIL empty_cnt: got %0d/%0d exp %0d/%0d", branch_cnt_o, mispredict_cnt_o, bc0, mc0); end
    idle();
    n_vec++; if (resolve_err_o !== 1'b0) begin n_err++; $display("FAIL empty_err_pulse: got %b exp 0", resolve_err_o); end
    push(32'hA00, 0, 1, 32'hA80);
    cycle(1, 32'hA10, 0, 0, '0, 1, 0, '0, 1);
    n_vec++; if (redirect_valid_o !== 1'b0 || occupancy_o !== 3'd0) begin n_err++; $display("FAIL flush: got %b/%0d exp 0/0", redirect_valid_o, occupancy_o); end
    n_vec++; if (int'(branch_cnt_o) != bc0 || int'(mispredict_cnt_o) != mc0) begin n_err++; $display("FAIL flush_cnt: got %0d/%0d exp %0d/%0d", branch_cnt_o, mispredict_cnt_o, bc0, mc0); end
    cycle(0, '0, 0, 0, '0, 1, 0, '0, 1);
    n_vec++; if (resolve_err_o !== 1'b0) begin n_err++; $display("FAIL flush_err: got %b exp 0", resolve_err_o); end
  endtask

  task automatic test_back_to_back();
    push(32'hB00, 0, 0, 32'h0);
    cycle(1, 32'hB04, 1, 1, 32'hB40, 1, 0, '0, 0);
    n_vec++; if (occupancy_o !== 3'd1 || redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_1: got %0d/%b exp 1/0", occupancy_o, redirect_valid_o); end
    cycle(1, 32'hB08, 0, 0, '0, 1, 1, 32'hB40, 0);
    n_vec++; if (occupancy_o !== 3'd1 || redirect_valid_o !== 1'b0) begin n_err++; $display("FAIL b2b_2: got %0d/%b exp 1/0", occupancy_o, redirect_valid_o); end
    resolve(1, 32'hC00);
    n_vec++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'hC00) begin n_err++; $display("FAIL b2b_3: got %b/%h exp 1/c00", redirect_valid_o, redirect_pc_o); end
  endtask

  task automatic test_random();
    logic        pv, c, t, rv, rt, fl;
    logic [31:0] pc, tgt, rtgt;
    for (int n = 0; n < 400; n++) begin
      n_vec++; if (push_ready_o !== (mq.size() < DEPTH)) begin n_err++; $display("FAIL rnd_ready@%0d: got %b exp %b", n, push_ready_o, mq.size() < DEPTH); end
      pv = ($urandom_range(0, 99) < 55);
      pc = {$urandom_range(0, 32'hFFFF), 15'h0, 1'b0} | (32'($urandom_range(0, 7)) << 1);
      c = $urandom_range(0, 1); t = $urandom_range(0, 1);
      tgt = 32'($urandom_range(0, 255)) << 2;
      rv = ($urandom_range(0, 99) < 40);
      fl = ($urandom_range(0, 19) == 0);
      if (mq.size() > 0 && $urandom_range(0, 99) < 60) begin
        rt = mq[0].t; rtgt = mq[0].tgt;
      end else begin
        rt = $urandom_range(0, 1); rtgt = 32'($urandom_range(0, 255)) << 2;
      end
      cycle(pv, pc, c, t, tgt, rv, rt, rtgt, fl);
      n_vec++; if (redirect_valid_o !== m_rv) begin n_err++; $display("FAIL rnd_rv@%0d: got %b exp %b", n, redirect_valid_o, m_rv); end
      n_vec++; if (redirect_pc_o !== m_rpc) begin n_err++; $display("FAIL rnd_rpc@%0d: got %h exp %h", n, redirect_pc_o, m_rpc); end
      n_vec++; if (resolve_err_o !== m_err) begin n_err++; $display("FAIL rnd_err@%0d: got %b exp %b", n, resolve_err_o, m_err); end
      n_vec++; if (occupancy_o !== 3'(mq.size())) begin n_err++; $display("FAIL rnd_occ@%0d: got %0d exp %0d", n, occupancy_o, mq.size()); end
      n_vec++; if (branch_cnt_o !== 16'(sat(m_bc, 65535)) || mispredict_cnt_o !== 16'(sat(m_mc, 65535))) begin n_err++; $display("FAIL rnd_cnt@%0d: got %0d/%0d exp %0d/%0d", n, branch_cnt_o, mispredict_cnt_o, m_bc, m_mc); end
      n_vec++; if (s_bc !== 2'(sat(m_bc, 3)) || s_mc !== 2'(sat(m_mc, 3))) begin n_err++; $display("FAIL rnd_satcnt@%0d: got %0d/%0d exp %0d/%0d", n, s_bc, s_mc, sat(m_bc, 3), sat(m_mc, 3)); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    push(32'hD00, 0, 1, 32'hD80);
    push(32'hD10, 0, 0, 32'h0);
    resolve(0, '0);
    n_vec++; if (redirect_valid_o !== 1'b1) begin n_err++; $display("FAIL ar_pre: got %b exp 1", redirect_valid_o); end
    #2 rst_i = 1'b1;
    #1;
    n_vec++; if (redirect_valid_o !== 1'b0 || redirect_pc_o !== 32'h0) begin n_err++; $display("FAIL ar_redirect: got %b/%h exp 0/0", redirect_valid_o, redirect_pc_o); end
    n_vec++; if (occupancy_o !== 3'd0 || push_ready_o !== 1'b1) begin n_err++; $display("FAIL ar_fifo: got %0d/%b exp 0/1", occupancy_o, push_ready_o); end
    n_vec++; if (branch_cnt_o !== 16'd0 || mispredict_cnt_o !== 16'd0) begin n_err++; $display("FAIL ar_cnt: got %0d/%0d exp 0/0", branch_cnt_o, mispredict_cnt_o); end
    do_reset();
    idle();
    n_vec++; if (redirect_valid_o !== 1'b0 || occupancy_o !== 3'd0) begin n_err++; $display("FAIL ar_after: got %b/%0d exp 0/0", redirect_valid_o, occupancy_o); end
  endtask

  initial begin
    test_reset();
    test_mispredict_taken();
    test_counter_saturation();
    test_mispredict_not_taken();
    test_full_backpressure();
    test_flush_on_mispredict();
    test_empty_resolve_and_flush();
    test_back_to_back();
    do_reset();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ibex_branch_resolve.md
Name: ibex_branch_resolve

Overview:
- Back end of the static branch-prediction path: IF pushes each predicted control-flow instruction into an in-order tracking FIFO; EX resolves them oldest-first.
- Compares actual outcome against the prediction and issues a registered redirect (mispredict) to the prefetch buffer.
- Flushes wrong-path entries and keeps saturating branch/mispredict counters for performance monitoring.

Parameters:
- DEPTH, 4, tracking-FIFO entries; power of two, >= 2
- CNT_W, 16, width of each performance counter

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active high
- push_valid_i  in  1  IF presents a control-flow instruction with its prediction
- push_ready_o  out  1  FIFO can accept (= not full)
- push_pc_i  in  32  PC of the instruction
- push_compressed_i  in  1  instruction is 16-bit (fall-through = pc+2, else pc+4)
- push_taken_i  in  1  predicted taken
- push_target_i  in  32  predicted target (meaningful when push_taken_i=1)
- resolve_valid_i  in  1  EX resolves the oldest tracked instruction this cycle
- resolve_taken_i  in  1  actual direction
- resolve_target_i  in  32  actual target when taken
- flush_i  in  1  external pipeline flush (exception/interrupt)
- redirect_valid_o  out  1  one-cycle pulse: mispredict, refetch required
- redirect_pc_o  out  32  correct next PC; valid with redirect_valid_o
- resolve_err_o  out  1  one-cycle pulse: resolve while FIFO empty
- occupancy_o  out  $clog2(DEPTH)+1  entries held
- branch_cnt_o  out  CNT_W  resolved instructions, saturating
- mispredict_cnt_o  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset (asynchronous on rst_i high): FIFO empty, pointers 0, all registered outputs 0, counters 0; push_ready_o reads 1 (derived from occupancy).
- Storage: circular FIFO, write/read pointers with wrap bit; full when pointers equal except wrap bit. Entry = {pc, compressed, taken, target}.
- Push accepted when push_valid_i & push_ready_o. push_ready_o has no combinational dependence on resolve_valid_i; a push into a full FIFO is not accepted, even if a pop happens the same cycle.
- Simultaneous accepted push and resolve on a non-empty FIFO: occupancy unchanged, both take effect.
- Resolve, FIFO non-empty: pop oldest entry and compare:
  - pred taken, actual not taken -> mispredict; redirect_pc = pc + (compressed ? 2 : 4), 32-bit modulo.
  - pred not taken, actual taken -> mispredict; redirect_pc = resolve_target_i.
  - both taken, target differs -> mispredict; redirect_pc = resolve_target_i.
  - otherwise correct, no redirect.
- Latency: redirect_valid_o/redirect_pc_o registered, asserted the cycle after the resolve, held for exactly 1 cycle. redirect_pc_o holds its last value when not valid.
- On mispredict, the whole FIFO is emptied at the same edge (younger entries are wrong-path); a push accepted that cycle is discarded.
- Resolve with FIFO empty: no pop, no counter update; resolve_err_o pulses the next cycle.
- flush_i has highest priority: FIFO emptied, any same-cycle push or resolve ignored, no redirect, no error, counters unchanged.
- Counters: branch_cnt_o += 1 per valid non-empty resolve; mispredict_cnt_o += 1 per mispredict; both saturate at 2^CNT_W-1, no wrap.
- Reset mid-operation: immediate return to reset state; any pending redirect pulse is lost.

Test Plan:
- Push {pc=0x100, taken=1, tgt=0xF0, c=0}, then resolve taken=0 -> next cycle redirect_valid_o=1, redirect_pc_o=0x104; occupancy 0; mispredict_cnt=1, branch_cnt=1.
- Push {pc=0x200, taken=0, c=1}, resolve taken=1, tgt=0x240 -> redirect_pc_o=0x240. Repeat with a correct-prediction case -> no redirect, branch_cnt increments only.
- Push 4 entries (DEPTH=4) -> push_ready_o=0. Next cycle push_valid_i=1 with a correct resolve -> push rejected, occupancy 3; following cycle push accepted -> occupancy 4.
- Fill 3 entries, mispredict on oldest while pushing a 4th -> occupancy 0 next cycle, 4th entry discarded, single redirect pulse.
- Resolve on empty FIFO -> resolve_err_o pulses 1 cycle, counters unchanged. flush_i with resolve mispredict same cycle -> no redirect, occupancy 0.
- Force CNT_W=2: 5 mispredicts -> mispredict_cnt_o stays 3. Assert rst_i mid-stream -> all outputs 0 asynchronously.
